// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;
  localparam int STARVE_W   = 8;

endpackage

// File: rtl/arb2_pick.sv
// rtl/arb2_pick.sv - combinational two-way winner selection
module arb2_pick
  import mem_arb_pkg::*;
#(
  parameter int MODE = MODE_RR
) (
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last,
  input  logic  force_b,
  output logic  grant_a,
  output logic  grant_b
);

  logic b_wins;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    b_wins  = 1'b0;
    if (req_a && req_b) begin
      // Ties: round-robin favours the port not served last; fixed mode favours A unless B is starving
      if (MODE == MODE_FIXED) begin
        b_wins = force_b;
      end else begin
        b_wins = (last == PORT_A);
      end
      grant_a = !b_wins;
      grant_b = b_wins;
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-cycle byte-lane memory between CPU port A and DMA port B
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MODE         = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic        a_wide,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic        b_wide,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        a_ack,
  output logic        b_ack,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic [15:0] a_rdata,
  output logic [15:0] b_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        mem_wide,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_LIMIT[STARVE_W-1:0];
  localparam logic [STARVE_W-1:0] ONE   = STARVE_W'(1);

  port_t               last;
  port_t               pend_port;
  logic                pend_valid;
  logic [STARVE_W-1:0] starve_cnt;
  logic                grant_a;
  logic                grant_b;
  logic                force_b;

  assign force_b = (MODE == MODE_FIXED) && (starve_cnt == LIMIT);

  arb2_pick #(.MODE(MODE)) u_pick (
    .req_a   (a_req),
    .req_b   (b_req),
    .last    (last),
    .force_b (force_b),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign a_ack = grant_a && rst_n;
  assign b_ack = grant_b && rst_n;

  always_comb begin
    mem_en   = 1'b0;
    mem_wr   = 1'b0;
    mem_wide = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_a) begin
      mem_en   = 1'b1;
      mem_wr   = a_wr;
      mem_wide = a_wide;
      mem_addr = a_addr;
      mem_din  = a_wdata;
    end else if (grant_b) begin
      mem_en   = 1'b1;
      mem_wr   = b_wr;
      mem_wide = b_wide;
      mem_addr = b_addr;
      mem_din  = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last       <= PORT_B;
      starve_cnt <= '0;
      pend_valid <= 1'b0;
      pend_port  <= PORT_A;
    end else begin
      if (grant_a) begin
        last <= PORT_A;
      end else if (grant_b) begin
        last <= PORT_B;
      end
      pend_valid <= (grant_a && !a_wr) || (grant_b && !b_wr);
      pend_port  <= grant_b ? PORT_B : PORT_A;
      if (MODE != MODE_FIXED || !b_req || grant_b) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + ONE;
      end
    end
  end

  // Read data is only presented on the port whose read is returning this cycle
  assign a_rvalid = pend_valid && (pend_port == PORT_A);
  assign b_rvalid = pend_valid && (pend_port == PORT_B);
  assign a_rdata  = a_rvalid ? mem_dout : 16'h0000;
  assign b_rdata  = b_rvalid ? mem_dout : 16'h0000;

endmodule
